// File: rtl/matrix_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_if
// Purpose  : Serial valid/ready front end for a 2x2 combinational multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_stream_if #(
  parameter int ELEM_W = 8,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ELEM_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ELEM_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*ELEM_W-1:0] mat_a,
  output logic [4*ELEM_W-1:0] mat_b,
  input  logic [4*ELEM_W-1:0] mat_res,
  output logic                busy
);

  localparam int c_MAT_W = 4 * ELEM_W;
  localparam int c_SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_in_cnt;
  logic [1:0]           r_out_cnt;
  logic [c_SET_W-1:0]   r_settle;
  logic [7*ELEM_W-1:0]  r_shadow;
  logic [c_MAT_W-1:0]   r_mat_a;
  logic [c_MAT_W-1:0]   r_mat_b;
  logic [c_MAT_W-1:0]   r_out_sr;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_capture   = 1'b0;
    case (r_state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && (r_in_cnt == 3'd7)) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_settle == c_SET_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        out_valid = 1'b1;
        if (out_ready && (r_out_cnt == 2'd3)) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Operands are published only on the 8th element so the multiplier sees
  // exactly one operand change per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_cnt <= 3'd0;
      r_shadow <= '0;
      r_mat_a  <= '0;
      r_mat_b  <= '0;
    end else if (w_in_fire) begin
      r_in_cnt <= r_in_cnt + 3'd1;
      r_shadow <= {r_shadow[6*ELEM_W-1:0], in_data};
      if (r_in_cnt == 3'd7) begin
        {r_mat_a, r_mat_b} <= {r_shadow, in_data};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
    end else if (r_state == S_CALC) begin
      if (w_capture) begin
        r_settle <= '0;
      end else begin
        r_settle <= r_settle + 1'b1;
      end
    end
  end

  // Zeros shift in behind the results, so out_data reads 0 outside SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_sr  <= '0;
      r_out_cnt <= 2'd0;
    end else if (w_capture) begin
      r_out_sr  <= mat_res;
      r_out_cnt <= 2'd0;
    end else if (w_out_fire) begin
      r_out_sr  <= {r_out_sr[c_MAT_W-ELEM_W-1:0], {ELEM_W{1'b0}}};
      r_out_cnt <= r_out_cnt + 2'd1;
    end
  end

  assign out_data = r_out_sr[c_MAT_W-1 -: ELEM_W];
  assign mat_a    = r_mat_a;
  assign mat_b    = r_mat_b;

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_if.sv
`default_nettype none
// Bench for matrix_stream_if: two instances (SETTLE=1 and SETTLE=3), directed
// test-plan frames followed by randomized frames checked against a model.
module tb_matrix_stream_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s  [2];
  logic [7:0]  id_s   [2];
  logic        iv_s   [2];
  logic        ir_s   [2];
  logic [7:0]  od_s   [2];
  logic        ov_s   [2];
  logic        or_s   [2];
  logic [31:0] ma_s   [2];
  logic [31:0] mb_s   [2];
  logic [31:0] mr_s   [2];
  logic        busy_s [2];

  logic [31:0] prev_a [2];
  logic [31:0] prev_b [2];

  int n_pass  = 0;
  int n_total = 0;

  // 2x2 product of frame f = {A, B} (m00 first), each element truncated to 8 bits.
  function automatic logic [31:0] mm(input logic [63:0] f);
    logic [7:0]  a [2][2];
    logic [7:0]  b [2][2];
    logic [31:0] r;
    int          acc;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        a[i][j] = f[63-8*(2*i+j) -: 8];
        b[i][j] = f[31-8*(2*i+j) -: 8];
      end
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int k = 0; k < 2; k++) acc += int'(a[i][k]) * int'(b[k][j]);
        r[31-8*(2*i+j) -: 8] = acc[7:0];
      end
    return r;
  endfunction

  assign mr_s[0] = mm({ma_s[0], mb_s[0]});
  assign mr_s[1] = mm({ma_s[1], mb_s[1]});

  matrix_stream_if #(.ELEM_W(8), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst_s[0]),
    .in_data(id_s[0]), .in_valid(iv_s[0]), .in_ready(ir_s[0]),
    .out_data(od_s[0]), .out_valid(ov_s[0]), .out_ready(or_s[0]),
    .mat_a(ma_s[0]), .mat_b(mb_s[0]), .mat_res(mr_s[0]), .busy(busy_s[0])
  );

  matrix_stream_if #(.ELEM_W(8), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst_s[1]),
    .in_data(id_s[1]), .in_valid(iv_s[1]), .in_ready(ir_s[1]),
    .out_data(od_s[1]), .out_valid(ov_s[1]), .out_ready(or_s[1]),
    .mat_a(ma_s[1]), .mat_b(mb_s[1]), .mat_res(mr_s[1]), .busy(busy_s[1])
  );

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s (dut%0d): observed %h expected %h", tag, d, obs, exp);
  endtask

  task automatic timeout_fail(input string tag, input int d);
    n_total++;
    $error("FAIL %s (dut%0d): timeout waiting for handshake", tag, d);
  endtask

  task automatic do_reset(input int d);
    iv_s[d]  = 1'b0;
    rst_s[d] = 1'b1;
    #1;
    chk("rst in_ready",  d, ir_s[d],   32'd1);
    chk("rst out_valid", d, ov_s[d],   32'd0);
    chk("rst out_data",  d, od_s[d],   32'd0);
    chk("rst mat_a",     d, ma_s[d],   32'd0);
    chk("rst mat_b",     d, mb_s[d],   32'd0);
    chk("rst busy",      d, busy_s[d], 32'd0);
    @(negedge clk);
    rst_s[d]  = 1'b0;
    prev_a[d] = '0;
    prev_b[d] = '0;
  endtask

  // gap: 0 none, 1 toggle, 2 random; stall: 0 none, 1 five cycles, 2 random.
  // ld_abort / out_abort: reset after that many accepts / outputs (8 / 4 = never).
  task automatic run_frame(input int d, input logic [63:0] f, input int gap,
                           input int stall, input bit junk, input int ld_abort,
                           input int out_abort);
    int          i = 0;
    int          k = 0;
    int          t = 0;
    int          s = 0;
    bit          tog = 1'b1;
    bit          want;
    int          settle = (d == 0) ? 1 : 3;
    logic [31:0] r = mm(f);

    while (i < 8) begin
      @(negedge clk);
      if (i == ld_abort) begin
        do_reset(d);
        return;
      end
      chk("load in_ready",  d, ir_s[d],   32'd1);
      chk("load busy",      d, busy_s[d], 32'd0);
      chk("load out_valid", d, ov_s[d],   32'd0);
      chk("load mat_a",     d, ma_s[d],   prev_a[d]);
      chk("load mat_b",     d, mb_s[d],   prev_b[d]);
      if (++t > 200) begin
        timeout_fail("load", d);
        return;
      end
      case (gap)
        0:       want = 1'b1;
        1:       want = tog;
        default: want = ($urandom_range(0, 2) != 0);
      endcase
      tog     = ~tog;
      iv_s[d] = want;
      id_s[d] = want ? f[63-8*i -: 8] : 8'($urandom);
      or_s[d] = 1'($urandom_range(0, 1));
      if (want) i++;
    end

    for (int j = 1; j <= settle + 1; j++) begin
      @(negedge clk);
      chk("calc mat_a",     d, ma_s[d],   f[63:32]);
      chk("calc mat_b",     d, mb_s[d],   f[31:0]);
      chk("calc busy",      d, busy_s[d], 32'd1);
      chk("calc in_ready",  d, ir_s[d],   32'd0);
      chk("out_valid rise", d, ov_s[d],   32'(j == settle + 1));
      iv_s[d] = junk;
      id_s[d] = junk ? 8'hFF : 8'h00;
      if (j <= settle) or_s[d] = 1'($urandom_range(0, 1));
    end
    prev_a[d] = f[63:32];
    prev_b[d] = f[31:0];

    while (k < 4) begin
      if (k == out_abort) begin
        do_reset(d);
        return;
      end
      chk("send out_valid", d, ov_s[d],   32'd1);
      chk("send out_data",  d, od_s[d],   32'(r[31-8*k -: 8]));
      chk("send in_ready",  d, ir_s[d],   32'd0);
      chk("send busy",      d, busy_s[d], 32'd1);
      case (stall)
        0:       or_s[d] = 1'b1;
        1:       or_s[d] = (s >= 5);
        default: or_s[d] = ($urandom_range(0, 3) != 0);
      endcase
      s++;
      if (or_s[d]) k++;
      @(negedge clk);
      if (s > 200) begin
        timeout_fail("send", d);
        return;
      end
    end
    chk("done out_valid", d, ov_s[d],   32'd0);
    chk("done in_ready",  d, ir_s[d],   32'd1);
    chk("done busy",      d, busy_s[d], 32'd0);
    chk("done mat_a",     d, ma_s[d],   f[63:32]);
    iv_s[d] = 1'b0;
    or_s[d] = 1'($urandom_range(0, 1));
  endtask

  localparam logic [63:0] c_F1 = 64'h01020304_05060708;
  localparam logic [63:0] c_F2 = 64'h02000002_03040506;

  initial begin
    logic [63:0] rf;
    for (int d = 0; d < 2; d++) begin
      rst_s[d]  = 1'b0;
      iv_s[d]   = 1'b0;
      or_s[d]   = 1'b0;
      id_s[d]   = 8'h00;
      prev_a[d] = '0;
      prev_b[d] = '0;
    end
    #2;
    do_reset(0);
    do_reset(1);

    // basic frame, input gaps, output backpressure
    run_frame(0, c_F1, 0, 0, 1'b0, 8, 4);
    run_frame(0, c_F1, 1, 0, 1'b0, 8, 4);
    run_frame(0, c_F1, 0, 1, 1'b0, 8, 4);
    // ignored input during CALC/SEND, then second frame
    run_frame(0, c_F1, 0, 0, 1'b1, 8, 4);
    run_frame(0, c_F2, 0, 0, 1'b1, 8, 4);
    // reset after 5 accepts, then during SEND after 2 outputs
    run_frame(0, c_F2, 0, 0, 1'b0, 5, 4);
    run_frame(0, c_F1, 0, 0, 1'b0, 8, 4);
    run_frame(0, c_F2, 0, 0, 1'b0, 8, 2);
    run_frame(0, c_F1, 1, 2, 1'b0, 8, 4);
    // SETTLE = 3
    run_frame(1, c_F1, 0, 0, 1'b0, 8, 4);
    run_frame(1, c_F2, 1, 1, 1'b1, 8, 4);

    for (int n = 0; n < 20; n++) begin
      rf = {$urandom, $urandom};
      run_frame(0, rf, 2, 2, 1'($urandom_range(0, 1)), 8, 4);
    end
    for (int n = 0; n < 6; n++) begin
      rf = {$urandom, $urandom};
      run_frame(1, rf, 2, 2, 1'($urandom_range(0, 1)), 8, 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_stream_if.md
# matrix_stream_if

Byte-stream front end for the 2x2 matrix multiplier. It receives eight 8-bit elements over a valid/ready input stream and presents them as packed operands `mat_a`/`mat_b` to the combinational multiplier. It then captures the packed product from `mat_res` and returns the four result elements over a valid/ready output stream. The block turns the multiplier's parallel interface into a serial producer/consumer interface, so it can sit between a UART/FIFO-style source and sink.

## Interface
- `ELEM_W`, 8, element width; packed matrices are `4*ELEM_W` bits, element order {m00, m01, m10, m11}, with m00 in the MSBs.
- `SETTLE`, 1, cycles allowed for the multiplier output to settle before capture (≥1).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  ELEM_W  input element.
- `in_valid`  in  1  source has an element on `in_data`.
- `in_ready`  out  1  block accepts an element this cycle.
- `out_data`  out  ELEM_W  result element.
- `out_valid`  out  1  `out_data` holds a valid result element.
- `out_ready`  in  1  sink accepts `out_data` this cycle.
- `mat_a`  out  4*ELEM_W  packed operand A to the multiplier.
- `mat_b`  out  4*ELEM_W  packed operand B to the multiplier.
- `mat_res`  in  4*ELEM_W  packed product from the multiplier.
- `busy`  out  1  high whenever state ≠ LOAD.

## Operation
- **States**
  - LOAD: collect 8 elements.
  - CALC: wait `SETTLE` cycles, then capture `mat_res`.
  - SEND: emit 4 elements.
- **Transitions**
  - LOAD → CALC on the 8th accepted element.
  - CALC → SEND when the settle counter expires.
  - SEND → LOAD on the 4th output handshake.
- **Input handshake**
  - An element is accepted when `in_valid && in_ready`.
  - `in_ready` = 1 only in LOAD.
  - `in_valid` asserted in CALC or SEND is ignored; that data is not consumed.
- **Input order**
  - Elements 0–3 fill A as m00, m01, m10, m11.
  - Elements 4–7 fill B in the same order.
  - Elements shift into an internal shadow register.
  - `mat_a`/`mat_b` update together, only on the cycle the 8th element is accepted, so the multiplier sees one operand change per frame.
- **Element counter**
  - 3 bits, range 0..7.
  - Increments per accepted element.
  - Wraps to 0 on the 8th element.
  - Holds when no handshake occurs.
- **Capture**
  - On the last CALC cycle, `mat_res` is loaded into the output shift register.
  - `mat_res` is not sampled at any other time.
- **Output handshake**
  - `out_valid` = 1 throughout SEND.
  - `out_data` = top `ELEM_W` bits of the shift register, i.e. r00 first, then r01, r10, r11.
  - The register shifts by `ELEM_W` only on `out_valid && out_ready`.
  - `out_data` must be stable while `out_valid && !out_ready`.
- **Arithmetic**: the block performs none; widths and truncation are the multiplier's.
- **Reset behaviour** (asynchronous, including mid-frame)
  - State → LOAD, counters → 0.
  - Partial input and any unsent results are discarded.
  - `mat_a`/`mat_b` → 0.

## Timing
- **Reset values**
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_data` = 0
  - `mat_a` = 0, `mat_b` = 0
  - `busy` = 0
- **Latency**
  - 8th element accepted at edge n.
  - `mat_a`/`mat_b` valid and `busy` = 1 after edge n.
  - Capture at edge n+`SETTLE`.
  - `out_valid` = 1 after edge n+`SETTLE`.
- **Output rate**: with `out_ready` held at 1, the 4 results leave on 4 consecutive cycles.
- **Back-to-back frames**
  - `in_ready` returns to 1 the cycle after the 4th output handshake.
  - Minimum frame period = 8 + `SETTLE` + 4 cycles.
- **Simultaneous events**
  - `in_valid` coincident with the final output handshake is not accepted that cycle.
  - `out_ready` outside SEND has no effect.

## Test plan
- **Basic frame**
  - Stimulus: reset, then stream 1,2,3,4,5,6,7,8 with `in_valid` = 1, `out_ready` = 1, and a behavioural 8-bit truncating multiplier model on `mat_res`.
  - Required: `mat_a` = 0x01020304, `mat_b` = 0x05060708; outputs 0x13, 0x16, 0x2B, 0x32, with first `out_valid` exactly `SETTLE`+1 cycles after the 8th accept.
- **Input gaps**
  - Stimulus: same frame with `in_valid` toggling 1/0 each cycle.
  - Required: same 4 outputs; `mat_a`/`mat_b` remain 0 until the 8th accept.
- **Output backpressure**
  - Stimulus: `out_ready` = 0 for 5 cycles after `out_valid` rises, then 1.
  - Required: `out_data` holds 0x13 throughout the stall; the sequence is then unchanged; `in_ready` stays 0.
- **Ignored input**
  - Stimulus: hold `in_valid` = 1 with data 0xFF during CALC and SEND, then send a second frame of 2,0,0,2 / 3,4,5,6.
  - Required: first results are unaffected; second results are 0x06, 0x08, 0x0A, 0x0C.
- **Reset mid-operation**
  - Stimulus: assert `rst` after 5 accepted elements, then again during SEND after 2 outputs.
  - Required: outputs return immediately to their reset values; the next full frame produces correct results with no stale data.
- **Settle parameter**
  - Stimulus: `SETTLE` = 3, basic frame.
  - Required: `out_valid` rises 4 cycles after the 8th accept; results 0x13, 0x16, 0x2B, 0x32.
